// File: rtl/lane_extractor.sv
// lane_extractor: serialises a packed word of LANES lanes into one lane
// per cycle on a valid/ready stream, tagged with lane index and last flag.
// Ports: clk, rst (synchronous, active-high);
//   word side: in_data, in_cnt, in_valid, in_ready;
//   lane side: out_data, out_idx, out_last, out_valid, out_ready;
//   busy mirrors out_valid.
// Build option EXTRACTOR_MSB_FIRST_EN: emit lanes from cnt_eff-1 down to 0.
module lane_extractor #(
  parameter  int LANES  = 16,
  parameter  int LANE_W = 1,
  localparam int IDX_W  = $clog2(LANES),
  localparam int CNT_W  = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [CNT_W-1:0]        in_cnt,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANE_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [LANES*LANE_W-1:0] word_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_eff;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_first;
  logic [IDX_W-1:0]        idx_end;
  logic [IDX_W-1:0]        idx_next;
  logic [IDX_W-1:0]        top_new;
  logic [IDX_W-1:0]        top_held;
  logic                    last;
  logic                    accept;
  logic                    step;

  // Zero and oversize counts both mean "the whole word".
  always_comb begin
    cnt_eff = in_cnt;
    if (in_cnt == '0 || in_cnt > CNT_W'(LANES))
      cnt_eff = CNT_W'(LANES);
  end

  assign top_new  = IDX_W'(cnt_eff - CNT_W'(1));
  assign top_held = IDX_W'(cnt_q - CNT_W'(1));

`ifdef EXTRACTOR_MSB_FIRST_EN
  assign idx_first = top_new;
  assign idx_end   = '0;
  assign idx_next  = idx_q - IDX_W'(1);
`else
  assign idx_first = '0;
  assign idx_end   = top_held;
  assign idx_next  = idx_q + IDX_W'(1);
`endif

  assign out_valid = (state_q == EMIT);
  assign busy      = out_valid;
  assign last      = out_valid && (idx_q == idx_end);
  assign out_last  = last;
  assign out_idx   = idx_q;

  // Gated by state so a finished word does not linger on the bus.
  assign out_data = out_valid
    ? word_q[int'(idx_q)*LANE_W +: LANE_W]
    : '0;

  always_comb begin
    state_d  = state_q;
    step     = 1'b0;
    in_ready = !out_valid || (out_ready && last);
    accept   = in_valid && in_ready;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (!last)
            step = 1'b1;
          else if (!accept)
            state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // accept and step are exclusive: accept in EMIT needs the last lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          word_q <= in_data;
          cnt_q  <= cnt_eff;
          idx_q  <= idx_first;
        end
        step: begin
          idx_q <= idx_next;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
